// File: rtl/div_radix2_engine.sv
`default_nettype none
// ============================================================================
// Module  : div_radix2_engine
// Brief   : Iterative radix-2 restoring unsigned divider, one quotient bit per
//           cycle. Optional macro DIV_EARLY_TERMINATE_EN enables CLZ-based
//           divisor normalisation and a one-cycle divide-by-zero path.
// Revision: 1.0
// ============================================================================
module div_radix2_engine #(
  parameter int DIV_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [DIV_WIDTH-1:0]         dividend,
  input  logic [DIV_WIDTH-1:0]         divisor,
  input  logic [$clog2(DIV_WIDTH)-1:0] dividend_CLZ,
  input  logic [$clog2(DIV_WIDTH)-1:0] divisor_CLZ,
  input  logic                         divisor_is_zero,
  output logic                         done,
  output logic [DIV_WIDTH-1:0]         quotient,
  output logic [DIV_WIDTH-1:0]         remainder
);

  localparam int CLZ_W = $clog2(DIV_WIDTH);
  localparam int CNT_W = CLZ_W + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]           state_q,     state_d;
  logic [CNT_W-1:0]     cnt_q,       cnt_d;
  logic [DIV_WIDTH:0]   rem_q,       rem_d;
  logic [DIV_WIDTH:0]   dvs_q,       dvs_d;
  logic [DIV_WIDTH-1:0] q_q,         q_d;
  logic                 done_q,      done_d;
  logic [DIV_WIDTH-1:0] quotient_q,  quotient_d;
  logic [DIV_WIDTH-1:0] remainder_q, remainder_d;

  logic                 short_case;
  logic [DIV_WIDTH-1:0] fast_quot;
  logic [DIV_WIDTH:0]   load_rem;
  logic [DIV_WIDTH-1:0] load_q;
  logic [DIV_WIDTH:0]   load_dvs;
  logic [CNT_W-1:0]     load_cnt;
  logic                 step_ge;
  logic [DIV_WIDTH:0]   next_rem;
  logic [DIV_WIDTH-1:0] next_q;
  logic [DIV_WIDTH:0]   next_dvs;

`ifdef DIV_EARLY_TERMINATE_EN
  logic [CNT_W-1:0] shift_k;

  // Divisor is pre-aligned under the dividend's MSB, so only K+1 bits remain.
  always_comb begin
    shift_k    = {1'b0, divisor_CLZ} - {1'b0, dividend_CLZ};
    short_case = divisor_is_zero | (dividend_CLZ > divisor_CLZ);
    fast_quot  = {DIV_WIDTH{divisor_is_zero}};
    load_rem   = {1'b0, dividend};
    load_q     = '0;
    load_dvs   = {1'b0, divisor} << shift_k;
    load_cnt   = shift_k + CNT_W'(1);
    step_ge    = (rem_q >= dvs_q);
    next_rem   = step_ge ? (rem_q - dvs_q) : rem_q;
    next_q     = {q_q[DIV_WIDTH-2:0], step_ge};
    next_dvs   = dvs_q >> 1;
  end
`else
  logic [DIV_WIDTH:0] shifted_rem;
  logic               unused_inputs;

  // Classic full-width loop: dividend bits shift out of q_q into the partial remainder.
  always_comb begin
    short_case    = 1'b0;
    fast_quot     = '0;
    load_rem      = '0;
    load_q        = dividend;
    load_dvs      = {1'b0, divisor};
    load_cnt      = CNT_W'(DIV_WIDTH);
    shifted_rem   = {rem_q[DIV_WIDTH-1:0], q_q[DIV_WIDTH-1]};
    step_ge       = (shifted_rem >= dvs_q);
    next_rem      = step_ge ? (shifted_rem - dvs_q) : shifted_rem;
    next_q        = {q_q[DIV_WIDTH-2:0], step_ge};
    next_dvs      = dvs_q;
    unused_inputs = ^{dividend_CLZ, divisor_CLZ, divisor_is_zero, rem_q[DIV_WIDTH]};
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    q_d         = q_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    case (state_q)
      ST_RUN: begin
        rem_d = next_rem;
        q_d   = next_q;
        dvs_d = next_dvs;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d     = ST_DONE;
          done_d      = 1'b1;
          quotient_d  = next_q;
          remainder_d = next_rem[DIV_WIDTH-1:0];
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (start && (state_q != ST_RUN)) begin
      if (short_case) begin
        state_d     = ST_DONE;
        done_d      = 1'b1;
        quotient_d  = fast_quot;
        remainder_d = dividend;
      end else begin
        state_d = ST_RUN;
        rem_d   = load_rem;
        q_d     = load_q;
        dvs_d   = load_dvs;
        cnt_d   = load_cnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      q_q         <= '0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      q_q         <= q_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  // The requester never issues start while a division is in flight.
  a_no_start_in_run : assert property (@(posedge clk) disable iff (rst)
    !(start && (state_q == ST_RUN)));

  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule
`default_nettype wire

// File: tb/tb_div_radix2_engine.sv
`default_nettype none
// ============================================================================
// Module  : tb_div_radix2_engine
// Brief   : Directed self-checking bench for div_radix2_engine.
// Revision: 1.0
// ============================================================================
module tb_div_radix2_engine;

  localparam int W = 32;
`ifdef DIV_EARLY_TERMINATE_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [4:0]   dividend_CLZ;
  logic [4:0]   divisor_CLZ;
  logic         divisor_is_zero;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  int checks   = 0;
  int failures = 0;

  div_radix2_engine #(.DIV_WIDTH(W)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .dividend        (dividend),
    .divisor         (divisor),
    .dividend_CLZ    (dividend_CLZ),
    .divisor_CLZ     (divisor_CLZ),
    .divisor_is_zero (divisor_is_zero),
    .done            (done),
    .quotient        (quotient),
    .remainder       (remainder)
  );

  always #5 clk = ~clk;

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] ca, input logic [4:0] cb, input logic dz);
    dividend        = a;
    divisor         = b;
    dividend_CLZ    = ca;
    divisor_CLZ     = cb;
    divisor_is_zero = dz;
    start           = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    dividend = '0; divisor = '0; dividend_CLZ = '0; divisor_CLZ = '0; divisor_is_zero = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (quotient !== 32'h0) begin failures++; $display("FAIL reset_quot got=%h exp=0", quotient); end
    checks++; if (remainder !== 32'h0) begin failures++; $display("FAIL reset_rem got=%h exp=0", remainder); end
    rst = 1'b0;
  endtask

  task automatic test_normal();
    int lat;
    // 100/7: K=4, N=5
    launch(32'd100, 32'd7, 5'd25, 5'd29, 1'b0);
    wait_done(lat);
    checks++; if (lat != (EARLY ? 6 : 33)) begin failures++; $display("FAIL norm_lat got=%0d exp=%0d", lat, EARLY ? 6 : 33); end
    checks++; if (quotient !== 32'd14) begin failures++; $display("FAIL norm_quot got=%0d exp=14", quotient); end
    checks++; if (remainder !== 32'd2) begin failures++; $display("FAIL norm_rem got=%0d exp=2", remainder); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL norm_pulse got=%b exp=0", done); end
  endtask

  task automatic test_short();
    int lat;
    launch(32'd5, 32'd9, 5'd29, 5'd28, 1'b0);
    wait_done(lat);
    checks++; if (lat != (EARLY ? 1 : 33)) begin failures++; $display("FAIL short_lat got=%0d exp=%0d", lat, EARLY ? 1 : 33); end
    checks++; if (quotient !== 32'd0) begin failures++; $display("FAIL short_quot got=%0d exp=0", quotient); end
    checks++; if (remainder !== 32'd5) begin failures++; $display("FAIL short_rem got=%0d exp=5", remainder); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL short_pulse got=%b exp=0", done); end
  endtask

  task automatic test_div_zero();
    int lat;
    launch(32'h1234, 32'h0, 5'd0, 5'd0, 1'b1);
    wait_done(lat);
    checks++; if (lat != (EARLY ? 1 : 33)) begin failures++; $display("FAIL dz_lat got=%0d exp=%0d", lat, EARLY ? 1 : 33); end
    checks++; if (quotient !== 32'hFFFF_FFFF) begin failures++; $display("FAIL dz_quot got=%h exp=ffffffff", quotient); end
    checks++; if (remainder !== 32'h1234) begin failures++; $display("FAIL dz_rem got=%h exp=1234", remainder); end
  endtask

  task automatic test_full_width();
    int lat;
    repeat (2) @(negedge clk);
    launch(32'hFFFF_FFFF, 32'd1, 5'd0, 5'd31, 1'b0);
    wait_done(lat);
    checks++; if (lat != 33) begin failures++; $display("FAIL full_lat got=%0d exp=33", lat); end
    checks++; if (quotient !== 32'hFFFF_FFFF) begin failures++; $display("FAIL full_quot got=%h exp=ffffffff", quotient); end
    checks++; if (remainder !== 32'h0) begin failures++; $display("FAIL full_rem got=%h exp=0", remainder); end
  endtask

  task automatic test_back_to_back();
    int lat;
    int lat2;
    int held_bad;
    repeat (2) @(negedge clk);
    launch(32'd100, 32'd7, 5'd25, 5'd29, 1'b0);
    wait_done(lat);
    checks++; if (quotient !== 32'd14) begin failures++; $display("FAIL b2b_first_quot got=%0d exp=14", quotient); end
    // 20/3 launched in the done cycle: K=3, N=4
    launch(32'd20, 32'd3, 5'd27, 5'd30, 1'b0);
    lat2 = -1;
    held_bad = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat2 = i;
        break;
      end
      if (quotient !== 32'd14 || remainder !== 32'd2) held_bad++;
    end
    checks++; if (held_bad != 0) begin failures++; $display("FAIL b2b_held bad_cycles=%0d exp=0", held_bad); end
    checks++; if (lat2 != (EARLY ? 5 : 33)) begin failures++; $display("FAIL b2b_lat got=%0d exp=%0d", lat2, EARLY ? 5 : 33); end
    checks++; if (quotient !== 32'd6) begin failures++; $display("FAIL b2b_quot got=%0d exp=6", quotient); end
    checks++; if (remainder !== 32'd2) begin failures++; $display("FAIL b2b_rem got=%0d exp=2", remainder); end
  endtask

  task automatic test_reset_abort();
    int lat;
    int done_seen;
    @(negedge clk);
    launch(32'hFFFF_FFFF, 32'd1, 5'd0, 5'd31, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    checks++; if (done_seen != 0) begin failures++; $display("FAIL abort_done got=%0d exp=0", done_seen); end
    checks++; if (quotient !== 32'h0) begin failures++; $display("FAIL abort_quot got=%h exp=0", quotient); end
    checks++; if (remainder !== 32'h0) begin failures++; $display("FAIL abort_rem got=%h exp=0", remainder); end
    launch(32'd100, 32'd7, 5'd25, 5'd29, 1'b0);
    wait_done(lat);
    checks++; if (lat != (EARLY ? 6 : 33)) begin failures++; $display("FAIL abort_new_lat got=%0d exp=%0d", lat, EARLY ? 6 : 33); end
    checks++; if (quotient !== 32'd14) begin failures++; $display("FAIL abort_new_quot got=%0d exp=14", quotient); end
    checks++; if (remainder !== 32'd2) begin failures++; $display("FAIL abort_new_rem got=%0d exp=2", remainder); end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_normal();
    test_short();
    test_div_zero();
    test_full_width();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
